// File: rtl/pio_pkg.sv
// Shared definitions for the parametrised input PIO: register offsets and edge-type encodings.
package pio_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned EDGE_RISING  = 32'd0;
    localparam int unsigned EDGE_FALLING = 32'd1;
    localparam int unsigned EDGE_ANY     = 32'd2;

endpackage

// File: rtl/pio_sync_chain.sv
// Per-bit multi-flop synchroniser for asynchronous inputs; output lags input by SYNC_STAGES clocks.
module pio_sync_chain #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    // Next value of each stage is the previous stage (stage 0 takes the raw pins).
    always_comb begin
        for (int s = 0; s < int'(SYNC_STAGES); s++) begin
            if (s == 0) begin
                stage_d[s] = d_i;
            end else begin
                stage_d[s] = stage_q[s-1];
            end
        end
    end

    // Synchroniser flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                stage_q[s] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pio_input_edge_irq.sv
// Avalon-MM input PIO: synchronised DATA, per-bit sticky edge capture with W1C, irq mask and
// a registered level interrupt.
module pio_input_edge_irq #(
    parameter int unsigned      WIDTH       = 3,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_MASK  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    import pio_pkg::*;

    logic [WIDTH-1:0]  sync_s;
    logic [WIDTH-1:0]  rise_s, fall_s, sel_s, detect_s;
    logic              wr_s;
    logic              unused_wd_s;

    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q, irq_d;
    logic              primed_q, primed_d;
    logic [2:0]        warm_q, warm_d;

    pio_sync_chain #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (in_port),
        .q_o    (sync_s)
    );

    assign wr_s        = chipselect & ~write_n;
    assign unused_wd_s = ^writedata;

    // Edge detection; held off until the reset zeros have left the synchroniser so that
    // pins already high at reset release never look like a rising edge.
    always_comb begin
        rise_s = sync_s & ~prev_q;
        fall_s = ~sync_s & prev_q;
        case (EDGE_TYPE)
            EDGE_RISING:  sel_s = rise_s;
            EDGE_FALLING: sel_s = fall_s;
            EDGE_ANY:     sel_s = rise_s | fall_s;
            default:      sel_s = rise_s;
        endcase
        if (primed_q) begin
            detect_s = sel_s;
        end else begin
            detect_s = {WIDTH{1'b0}};
        end
    end

    // Warm-up counter and primed flag.
    always_comb begin
        if (primed_q) begin
            warm_d   = warm_q;
            primed_d = 1'b1;
        end else begin
            warm_d   = warm_q + 3'd1;
            primed_d = (warm_q == 3'(SYNC_STAGES));
        end
    end

    // Register file next state: a new edge beats a simultaneous W1C on the same bit.
    always_comb begin
        prev_d = sync_s;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (detect_s[i]) begin
                edge_cap_d[i] = 1'b1;
            end else if (wr_s && (address == ADDR_EDGE) && writedata[i]) begin
                edge_cap_d[i] = 1'b0;
            end else begin
                edge_cap_d[i] = edge_cap_q[i];
            end
        end
        if (wr_s && (address == ADDR_MASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end else begin
            irq_mask_d = irq_mask_q;
        end
        irq_d = |(edge_cap_q & irq_mask_q);
    end

    // Read mux, loaded every clock from pre-write state.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = sync_s;
            ADDR_RSVD: readdata_d = 32'd0;
            ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_cap_q;
            default:   readdata_d = 32'd0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= {WIDTH{1'b0}};
            edge_cap_q <= {WIDTH{1'b0}};
            irq_mask_q <= RESET_MASK;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
            primed_q   <= 1'b0;
            warm_q     <= 3'd0;
        end else begin
            prev_q     <= prev_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            primed_q   <= primed_d;
            warm_q     <= warm_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Randomised and directed bench for pio_input_edge_irq: a 3-bit rising-edge instance and a
// 32-bit any-edge instance share one bus and are checked against a sample-history model.
module tb_pio_input_edge_irq;

    localparam int          S    = 2;
    localparam logic [31:0] RM32 = 32'h8000_0001;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        cs = 1'b0;
    logic        wr_n = 1'b1;
    logic [31:0] wd = 32'd0;
    logic [2:0]  in3 = 3'd0;
    logic [31:0] in32 = 32'd0;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: every pin sample taken since reset, plus expected register values.
    logic [31:0] q3[$];
    logic [31:0] q32[$];
    logic [31:0] m_mask [2];
    logic [31:0] m_ecap [2];
    logic [31:0] m_rd   [2];
    logic        m_irq  [2];

    always #5 clk = ~clk;

    pio_input_edge_irq #(.WIDTH(3), .SYNC_STAGES(S), .EDGE_TYPE(0)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wr_n),
        .writedata(wd), .in_port(in3), .readdata(rd0), .irq(irq0));

    pio_input_edge_irq #(.WIDTH(32), .SYNC_STAGES(S), .EDGE_TYPE(2), .RESET_MASK(RM32)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wr_n),
        .writedata(wd), .in_port(in32), .readdata(rd1), .irq(irq1));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_samp(input int k, input int j);
        if (k == 0) return (j >= 1 && j <= q3.size()) ? q3[j-1] : 32'd0;
        return (j >= 1 && j <= q32.size()) ? q32[j-1] : 32'd0;
    endfunction

    task automatic model_reset();
        q3.delete();
        q32.delete();
        m_mask[0] = 32'd0;
        m_mask[1] = RM32;
        for (int k = 0; k < 2; k++) begin
            m_ecap[k] = 32'd0;
            m_rd[k]   = 32'd0;
            m_irq[k]  = 1'b0;
        end
    endtask

    // One clock of the spec: DATA shows the pin value sampled S edges back; an edge is a change
    // between two consecutive post-reset samples; irq/readdata use pre-edge register values.
    task automatic model_step();
        logic [31:0] wm, cur, old, det, clr, rdn;
        int n;
        for (int k = 0; k < 2; k++) begin
            wm  = (k == 0) ? 32'h0000_0007 : 32'hFFFF_FFFF;
            n   = ((k == 0) ? q3.size() : q32.size()) + 1;
            cur = get_samp(k, n - S);
            old = get_samp(k, n - S - 1);
            det = 32'd0;
            if (n - S - 1 >= 1) det = (k == 0) ? (cur & ~old) : (cur ^ old);
            case (addr)
                2'd0:    rdn = cur;
                2'd2:    rdn = m_mask[k];
                2'd3:    rdn = m_ecap[k];
                default: rdn = 32'd0;
            endcase
            m_rd[k]  = rdn;
            m_irq[k] = |(m_ecap[k] & m_mask[k]);
            clr = (cs && !wr_n && addr == 2'd3) ? (wd & wm) : 32'd0;
            m_ecap[k] = (det | (m_ecap[k] & ~clr)) & wm;
            if (cs && !wr_n && addr == 2'd2) m_mask[k] = wd & wm;
        end
        q3.push_back({29'd0, in3});
        q32.push_back(in32);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("rd3", rd0, m_rd[0]);
        check_eq("irq3", {31'd0, irq0}, {31'd0, m_irq[0]});
        check_eq("rd32", rd1, m_rd[1]);
        check_eq("irq32", {31'd0, irq1}, {31'd0, m_irq[1]});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr = a; wd = d; cs = 1'b1; wr_n = 1'b0;
        tick();
        cs = 1'b0; wr_n = 1'b1;
    endtask

    // Called at a negedge; releases reset at a later negedge.
    task automatic do_reset(input logic [2:0] v3, input logic [31:0] v32);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_irq3", {31'd0, irq0}, 32'd0);
        check_eq("rst_irq32", {31'd0, irq1}, 32'd0);
        check_eq("rst_rd3", rd0, 32'd0);
        check_eq("rst_rd32", rd1, 32'd0);
        in3 = v3; in32 = v32;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        do_reset(3'b111, 32'd0);

        // Pins held high through reset: DATA after S+1 clocks, no edge, no irq.
        addr = 2'd0;
        ticks(S);
        check_eq("data_early", rd0, 32'd0);
        tick();
        check_eq("data_lat", rd0, 32'd7);
        addr = 2'd3;
        ticks(2);
        check_eq("ecap_rst", rd0, 32'd0);
        check_eq("irq_rst", {31'd0, irq0}, 32'd0);

        // Rising edge on bit0 with mask 001: irq exactly S+2 clocks after the pin change.
        bus_write(2'd2, 32'd1);
        in3 = 3'b000;
        ticks(4);
        bus_write(2'd3, 32'd7);
        ticks(2);
        in3 = 3'b001;
        for (int k = 1; k <= S + 2; k++) begin
            tick();
            if (k == S + 1) check_eq("irq_lat_early", {31'd0, irq0}, 32'd0);
        end
        check_eq("irq_lat", {31'd0, irq0}, 32'd1);
        check_eq("ecap_b0", rd0, 32'd1);
        bus_write(2'd3, 32'd0);
        tick();
        check_eq("w0_keep", rd0, 32'd1);
        bus_write(2'd3, 32'd1);
        tick();
        check_eq("w1c_rd", rd0, 32'd0);
        check_eq("w1c_irq", {31'd0, irq0}, 32'd0);

        // W1C on bit1 in the same clock as a new bit1 edge: the edge wins.
        in3 = 3'b011; ticks(3);
        in3 = 3'b001; ticks(3);
        in3 = 3'b011; ticks(2);
        bus_write(2'd3, 32'd2);
        tick();
        check_eq("w1c_vs_edge", rd0 & 32'd2, 32'd2);

        // 32-bit any-edge: bit31 high, W1C, then low; captured both times.
        bus_write(2'd3, 32'hFFFF_FFFF);
        in32 = 32'h8000_0000; ticks(3);
        tick();
        check_eq("b31_rise", rd1 & 32'h8000_0000, 32'h8000_0000);
        bus_write(2'd3, 32'h8000_0000);
        tick();
        check_eq("b31_clr", rd1 & 32'h8000_0000, 32'd0);
        in32 = 32'd0; ticks(3);
        tick();
        check_eq("b31_fall", rd1 & 32'h8000_0000, 32'h8000_0000);

        // Mask gating, then async irq drop on reset.
        bus_write(2'd3, 32'h7);
        in3 = 3'b101; ticks(3);
        bus_write(2'd2, 32'd0);
        ticks(2);
        check_eq("mask0_irq", {31'd0, irq0}, 32'd0);
        bus_write(2'd2, 32'd4);
        check_eq("mask_irq_early", {31'd0, irq0}, 32'd0);
        tick();
        check_eq("mask_irq", {31'd0, irq0}, 32'd1);
        #2;
        do_reset(3'b000, 32'd0);

        // Randomised traffic.
        for (int it = 0; it < 2500; it++) begin
            if ($urandom_range(0, 799) == 0) do_reset(3'($urandom), $urandom);
            cs   = ($urandom_range(0, 3) != 0);
            wr_n = ($urandom_range(0, 3) != 0);
            addr = 2'($urandom_range(0, 3));
            wd   = $urandom & $urandom;
            if ($urandom_range(0, 2) == 0) in3 = 3'($urandom);
            if ($urandom_range(0, 2) == 0) in32 = in32 ^ (32'd1 << $urandom_range(0, 31));
            if ($urandom_range(0, 19) == 0) in32 = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
